// File: rtl/c_add_accum_if.sv
// rtl/c_add_accum_if.sv - sample/result handshake bundle for c_add_accum
//
// Purpose : groups the upstream sample stream and downstream result stream
//           of the window accumulator into one interface.
// Signals : data_in/valid_in/ready_out  - sample from the n-to-1 adder
//           data_out/valid_out/ready_in - completed window total
//           overflow_out                - presented window exceeded range
// Modports: slave  - the accumulator itself
//           master - the environment driving samples and consuming results
interface c_add_accum_if #(
  parameter int in_width  = 10,
  parameter int acc_width = 16
);
  logic [in_width-1:0]  data_in;
  logic                 valid_in;
  logic                 ready_out;
  logic [acc_width-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 overflow_out;

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, overflow_out
  );

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, overflow_out
  );
endinterface

// File: rtl/c_add_accum.sv
// rtl/c_add_accum.sv - windowed accumulator of adder sums with result handshake
//
// Purpose : sums `window` accepted samples into an acc_width total, presents
//           the total with a valid/ready handshake and flags overflow.
//           Build option C_ADD_ACCUM_SAT_EN: accumulator saturates at
//           2^acc_width-1 instead of wrapping; overflow_out is identical in
//           both builds.
// Ports   : clk   - rising-edge clock
//           reset - synchronous, active-high
//           bus   - c_add_accum_if.slave (samples in, results out)
module c_add_accum #(
  parameter int in_width  = 10,
  parameter int acc_width = 16,
  parameter int window    = 8
) (
  input  logic           clk,
  input  logic           reset,
  c_add_accum_if.slave   bus
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  // window=1 still needs a (constant-zero) counter bit.
  localparam int cnt_w = (window < 2) ? 1 : $clog2(window);
  localparam logic [cnt_w-1:0]     last_cnt = cnt_w'(window - 1);
  localparam logic [acc_width-1:0] acc_max  = '1;

  state_t               state_q;
  logic [acc_width-1:0] acc_q;
  logic [cnt_w-1:0]     cnt_q;
  logic                 win_ovf_q;
  logic [acc_width-1:0] result_q;
  logic                 ovf_out_q;
  logic                 ready_q;
  logic                 valid_q;

  logic [acc_width:0]   sum_full;
  logic                 carry;
  logic                 ovf_next;
  logic [acc_width-1:0] acc_next;
  logic                 accept;
  logic                 last_sample;

  // One extra bit catches the carry out of acc_width.
  assign sum_full    = {1'b0, acc_q} + {{(acc_width - in_width + 1){1'b0}}, bus.data_in};
  assign carry       = sum_full[acc_width];
  assign ovf_next    = win_ovf_q | carry;

`ifdef C_ADD_ACCUM_SAT_EN
  // Once the window has overflowed the accumulator stays pinned at max.
  assign acc_next    = ovf_next ? acc_max : sum_full[acc_width-1:0];
`else
  assign acc_next    = sum_full[acc_width-1:0];
`endif

  // ready_q is high exactly in ACCUM, so this is the sample handshake.
  assign accept      = bus.valid_in && ready_q;
  assign last_sample = (cnt_q == last_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      win_ovf_q <= 1'b0;
      result_q  <= '0;
      ovf_out_q <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (last_sample) begin
              // Final sample goes straight into the result; the running
              // state is cleared so the next window starts from zero.
              result_q  <= acc_next;
              ovf_out_q <= ovf_next;
              acc_q     <= '0;
              cnt_q     <= '0;
              win_ovf_q <= 1'b0;
              state_q   <= HOLD;
              ready_q   <= 1'b0;
              valid_q   <= 1'b1;
            end else begin
              acc_q     <= acc_next;
              cnt_q     <= cnt_q + cnt_w'(1);
              win_ovf_q <= ovf_next;
            end
          end
        end
        HOLD: begin
          // valid_in is ignored here; result and flag stay frozen until taken.
          if (bus.ready_in) begin
            state_q   <= ACCUM;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            ovf_out_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ACCUM;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_out    = ready_q;
  assign bus.valid_out    = valid_q;
  assign bus.data_out     = result_q;
  assign bus.overflow_out = ovf_out_q;

endmodule

// File: doc/c_add_accum.md
C_ADD_ACCUM -- requirements
Module: c_add_accum

Interface
REQ-001 SHALL have parameter in_width, default 10, meaning width of each incoming sum from the n-to-1 adder (clogb(num_ports)+width for 4 ports of 8 bits).
REQ-002 SHALL have parameter acc_width, default 16, meaning accumulator and result width; legal only when acc_width >= in_width.
REQ-003 SHALL have parameter window, default 8, meaning the number of valid samples per result; legal range 1..65535.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning the reset; reset is synchronous and active-high.
REQ-006 SHALL have port data_in, input, in_width, meaning the unsigned sum from the upstream adder.
REQ-007 SHALL have port valid_in, input, 1, meaning data_in holds a sample this cycle.
REQ-008 SHALL have port ready_out, output, 1, meaning the block accepts a sample this cycle.
REQ-009 SHALL have port data_out, output, acc_width, meaning the completed window total.
REQ-010 SHALL have port valid_out, output, 1, meaning data_out is valid.
REQ-011 SHALL have port ready_in, input, 1, meaning downstream accepts data_out.
REQ-012 SHALL have port overflow_out, output, 1, meaning the presented window exceeded 2^acc_width-1.

Function
REQ-013 SHALL implement two states: ACCUM, which has ready_out=1 and valid_out=0, and HOLD, which has ready_out=0 and valid_out=1.
REQ-014 SHALL, in ACCUM, count a sample only when valid_in=1; sample acceptance is valid_in && ready_out.
REQ-015 SHALL, on each accepted sample, add data_in (zero-extended to acc_width) to the accumulator and increment the sample counter.
REQ-016 SHALL, on the accepted sample that brings the count to window, load the result register with accumulator+data_in, clear the accumulator and counter, and enter HOLD.
REQ-017 SHALL present the result with one cycle of latency: valid_out=1 in the cycle after the final sample.
REQ-018 SHALL leave the accumulator, counter and inputs unchanged while valid_in=0 in ACCUM.
REQ-019 SHALL, in HOLD, keep data_out and overflow_out stable until valid_out && ready_in.
REQ-020 SHALL ignore valid_in in HOLD, including in the handshake cycle itself.
REQ-021 SHALL return to ACCUM in the cycle after the handshake and accept a sample in that cycle.
REQ-022 SHALL, when window=1, make every accepted sample produce a result; the counter SHALL be at least 1 bit wide.
REQ-023 SHALL set overflow_out when any addition in the window carries out of acc_width bits; the flag is sticky within the window and cleared when the next window starts.
REQ-024 SHALL drive data_out with the last result in ACCUM; its value there is don't-care to consumers.

Reset
REQ-025 SHALL, on reset=1 at a rising clk edge, set the state to ACCUM, clear the accumulator, counter and overflow, and set data_out to 0.
REQ-026 SHALL, after reset, drive ready_out=1, valid_out=0, data_out=0 and overflow_out=0.
REQ-027 SHALL, on reset mid-window or in HOLD, discard the partial window or the pending result without emitting it.

Configuration
REQ-028 SHALL use macro C_ADD_ACCUM_SAT_EN as the single configuration feature.
REQ-029 SHALL, with C_ADD_ACCUM_SAT_EN defined, make the accumulator saturate at 2^acc_width-1 on overflow and hold that value for the rest of the window.
REQ-030 SHALL, without C_ADD_ACCUM_SAT_EN, make the accumulator wrap modulo 2^acc_width; overflow_out behaves the same in both builds.

Verification
REQ-031 SHALL cover basic accumulation: defaults, 8 consecutive samples of 5 -> valid_out=1 next cycle, data_out=40, overflow_out=0.
REQ-032 SHALL cover sparse input: 8 samples of 3 with valid_in low for 2 cycles between each -> data_out=24, with no sample lost or double-counted.
REQ-033 SHALL cover backpressure: ready_in=0 for 3 cycles after a result, with valid_in=1 and data_in=7 -> data_out held, ready_out=0, samples ignored; the next window starts clean after the handshake.
REQ-034 SHALL cover overflow: acc_width=12, 8 samples of 1020 -> with SAT_EN, data_out=4095 and overflow_out=1; without SAT_EN, data_out=4064 and overflow_out=1.
REQ-035 SHALL cover reset mid-window: reset after 3 samples of 9, then 8 samples of 1 -> data_out=8.
REQ-036 SHALL cover window=1: a sample stream of 4, 6 with ready_in=1 -> results 4, then 6, each followed by one ACCUM cycle.
